// File: rtl/sabana_vec_addsub.sv
// Job-based add/subtract/accumulate engine. A start pulse launches a job of len operand pairs.
// Results leave on a back-pressurable valid/ready port, with optional unsigned saturation.
module sabana_vec_addsub #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LEN_W    = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             finish,
  output logic             overflow,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] y_out,
  output logic             y_valid,
  input  logic             y_ready
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] ModeSub = 2'd1;
  localparam logic [1:0] ModeAcc = 2'd2;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH+1:0] sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             in_hs, out_hs;

  // Two extra bits: acc + a + b can carry past WIDTH+1 bits in accumulate mode.
  always_comb begin
    sum_w  = {2'b00, a_in} + {2'b00, b_in} + ((mode_q == ModeAcc) ? {2'b00, acc_q} : '0);
    diff_w = {1'b0, a_in} - {1'b0, b_in};
    if (mode_q == ModeSub) begin
      res_ovf = diff_w[WIDTH];
      res     = (SATURATE && res_ovf) ? '0 : diff_w[WIDTH-1:0];
    end else begin
      res_ovf = |sum_w[WIDTH+1:WIDTH];
      res     = (SATURATE && res_ovf) ? '1 : sum_w[WIDTH-1:0];
    end
  end

  assign in_ready = (state_q == StRun) && (remaining_q != '0) && (!y_valid_q || y_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = y_valid_q && y_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
    ovf_d       = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = len;
          mode_d      = mode;
          acc_d       = '0;
          ovf_d       = 1'b0;
          state_d     = (len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (in_hs) begin
          y_d         = res;
          y_valid_d   = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
          if (mode_q == ModeAcc) acc_d = res;
          if (res_ovf) ovf_d = 1'b1;
        end else if (out_hs) begin
          y_valid_d = 1'b0;
        end
        // remaining == 0 rules out a concurrent input, so this is the final result leaving.
        if (out_hs && (remaining_q == '0)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      mode_q      <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign finish   = (state_q == StDone);
  assign overflow = ovf_q;
  assign y_out    = y_q;
  assign y_valid  = y_valid_q;

endmodule

// File: tb/tb_sabana_vec_addsub.sv
// Directed bench for sabana_vec_addsub: a wrapping and a saturating instance share one stimulus.
module tb_sabana_vec_addsub;

  typedef logic [31:0] vec8_t [8];

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] len;
  logic [1:0]  mode;
  logic        in_valid;
  logic [31:0] a_in, b_in;
  logic        y_ready;

  logic        busy, finish, overflow, in_ready, y_valid;
  logic [31:0] y_out;
  logic        busy_s, finish_s, overflow_s, in_ready_s, y_valid_s;
  logic [31:0] y_out_s;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sabana_vec_addsub #(.WIDTH(32), .LEN_W(16), .SATURATE(1'b0)) dut (
    .clock(clock), .reset(reset), .start(start), .len(len), .mode(mode),
    .busy(busy), .finish(finish), .overflow(overflow),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready)
  );

  sabana_vec_addsub #(.WIDTH(32), .LEN_W(16), .SATURATE(1'b1)) dut_s (
    .clock(clock), .reset(reset), .start(start), .len(len), .mode(mode),
    .busy(busy_s), .finish(finish_s), .overflow(overflow_s),
    .in_valid(in_valid), .in_ready(in_ready_s), .a_in(a_in), .b_in(b_in),
    .y_out(y_out_s), .y_valid(y_valid_s), .y_ready(y_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic do_start(input logic [15:0] l, input logic [1:0] m);
    start = 1'b1;
    len   = l;
    mode  = m;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Streams nsend pairs and collects ncol results against ev. Returns at the falling edge
  // following the edge on which the last collected result was accepted.
  task automatic run_pairs(input int nsend, input int ncol, input bit toggle, input int pulse_cyc,
                           input vec8_t av, input vec8_t bv, input vec8_t ev);
    int          sent, got, cyc;
    bit          stalled;
    logic [31:0] prev_y;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; prev_y = '0;
    while (got < ncol && cyc < 100) begin
      if (stalled) chk("stall_hold", y_out, prev_y);
      chk("no_early_finish", finish, 0);
      y_ready  = toggle ? (cyc % 2 == 0) : 1'b1;
      in_valid = (sent < nsend);
      a_in     = av[sent % 8];
      b_in     = bv[sent % 8];
      start    = (cyc == pulse_cyc);
      len      = 16'd1;
      #1;
      if (y_valid && !y_ready) chk("ready_gate", in_ready, 0);
      if (y_valid && y_ready) begin
        chk("y", y_out, ev[got % 8]);
        got++;
      end
      stalled = y_valid && !y_ready;
      prev_y  = y_out;
      if (in_valid && in_ready) sent++;
      cyc++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    y_ready  = 1'b1;
    chk("result_count", got, ncol);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; mode = '0;
    in_valid = 1'b0; a_in = '0; b_in = '0; y_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_out", y_out, 0);
    reset = 1'b0;
    @(negedge clock);

    // Add burst with a carry-out on the last pair.
    do_start(16'd3, 2'd0);
    chk("add_busy", busy, 1);
    chk("add_in_ready", in_ready, 1);
    run_pairs(3, 3, 1'b0, -1, '{1, 10, 32'hFFFF_FFFF, 0, 0, 0, 0, 0},
              '{2, 20, 1, 0, 0, 0, 0, 0}, '{3, 30, 0, 0, 0, 0, 0, 0});
    chk("add_finish", finish, 1);
    chk("add_busy_done", busy, 1);
    chk("add_overflow", overflow, 1);
    chk("add_y_valid_done", y_valid, 0);
    @(negedge clock);
    chk("add_finish_low", finish, 0);
    chk("add_busy_low", busy, 0);
    chk("add_overflow_held", overflow, 1);

    // Saturation: add clamps high, sub clamps to zero; wrapping instance shown alongside.
    do_start(16'd1, 2'd0);
    chk("sat_ovf_cleared", overflow_s, 0);
    in_valid = 1'b1; a_in = 32'hFFFF_FFF0; b_in = 32'h20;
    @(negedge clock);
    in_valid = 1'b0;
    chk("sat_add_valid", y_valid_s, 1);
    chk("sat_add_y", y_out_s, 32'hFFFF_FFFF);
    chk("sat_add_ovf", overflow_s, 1);
    chk("wrap_add_y", y_out, 32'h10);
    @(negedge clock);
    chk("sat_add_finish", finish_s, 1);
    @(negedge clock);
    do_start(16'd1, 2'd1);
    chk("sat_ovf_cleared2", overflow_s, 0);
    in_valid = 1'b1; a_in = 32'd5; b_in = 32'd9;
    @(negedge clock);
    in_valid = 1'b0;
    chk("sat_sub_y", y_out_s, 0);
    chk("sat_sub_ovf", overflow_s, 1);
    chk("wrap_sub_y", y_out, 32'hFFFF_FFFC);
    chk("wrap_sub_ovf", overflow, 1);
    @(negedge clock);
    chk("sat_sub_finish", finish_s, 1);
    @(negedge clock);

    // Accumulate with y_ready toggling.
    do_start(16'd4, 2'd2);
    run_pairs(4, 4, 1'b1, -1, '{1, 2, 3, 4, 0, 0, 0, 0}, '{1, 2, 3, 4, 0, 0, 0, 0},
              '{2, 6, 12, 20, 0, 0, 0, 0});
    chk("acc_finish", finish, 1);
    chk("acc_overflow", overflow, 0);
    @(negedge clock);

    // Zero-length job.
    do_start(16'd0, 2'd0);
    chk("zero_finish", finish, 1);
    chk("zero_y_valid", y_valid, 0);
    chk("zero_in_ready", in_ready, 0);
    @(negedge clock);
    chk("zero_finish_low", finish, 0);
    chk("zero_busy_low", busy, 0);

    // Start pulsed mid-job must not change the count.
    do_start(16'd5, 2'd0);
    run_pairs(5, 5, 1'b0, 2, '{1, 2, 3, 4, 5, 0, 0, 0}, '{1, 1, 1, 1, 1, 0, 0, 0},
              '{2, 3, 4, 5, 6, 0, 0, 0});
    chk("ign_finish", finish, 1);
    @(negedge clock);
    chk("ign_idle", busy, 0);
    chk("ign_no_extra", y_valid, 0);

    // Reset after three results of an eight-pair job.
    do_start(16'd8, 2'd0);
    run_pairs(8, 3, 1'b0, -1, '{1, 2, 3, 4, 5, 6, 7, 8}, '{0, 0, 0, 0, 0, 0, 0, 0},
              '{1, 2, 3, 0, 0, 0, 0, 0});
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_finish", finish, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_y_valid", y_valid, 0);
    chk("mid_rst_y_out", y_out, 0);
    chk("mid_rst_sat_busy", busy_s, 0);
    chk("mid_rst_sat_in_ready", in_ready_s, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_no_finish", finish, 0);
    do_start(16'd1, 2'd0);
    run_pairs(1, 1, 1'b0, -1, '{7, 0, 0, 0, 0, 0, 0, 0}, '{8, 0, 0, 0, 0, 0, 0, 0},
              '{15, 0, 0, 0, 0, 0, 0, 0});
    chk("post_rst_finish", finish, 1);
    @(negedge clock);

    // Full throughput: 100 pairs, result k is 3k, finish during cycle 102 after start.
    do_start(16'd100, 2'd0);
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) begin
        chk("thru_valid", y_valid, 1);
        chk("thru_y", y_out, 32'(3 * (k - 1)));
      end
      chk("thru_no_finish", finish, 0);
      y_ready  = 1'b1;
      in_valid = (k < 100);
      a_in     = 32'(k);
      b_in     = 32'(2 * k);
      @(negedge clock);
    end
    chk("thru_finish", finish, 1);
    chk("thru_y_valid_low", y_valid, 0);
    @(negedge clock);
    chk("thru_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
